// File: rtl/lcla_multiword_seq_pkg.sv
// Shared constants for the multi-word LCLA sequencer: slice width, state codes
// and the slice-index width helper.
package lcla_seq_pkg;

  localparam int SLICE_W = 16;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADD  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Smallest r with 2**r >= n; used to size the slice index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcla_multiword_seq_if.sv
// Request/response bundle between a controller (master) and the sequencer (slave).
interface lcla_multiword_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = lcla_seq_pkg::SLICE_W * WORDS;

  logic         Start_in;
  logic         Sub_in;
  logic [W-1:0] A_in;
  logic [W-1:0] B_in;
  logic         C_in;
  logic         Ready_out;
  logic         Busy_out;
  logic [W-1:0] S_out;
  logic         C_out;
  logic         Done_out;

  modport master (
    output Start_in, Sub_in, A_in, B_in, C_in,
    input  Ready_out, Busy_out, S_out, C_out, Done_out
  );

  modport slave (
    input  Start_in, Sub_in, A_in, B_in, C_in,
    output Ready_out, Busy_out, S_out, C_out, Done_out
  );

endinterface

// File: rtl/lcla_multiword_seq_lcla16.sv
// LCLA_16: purely combinational 16-bit adder, four 4-bit groups with
// group-level carry lookahead.
module LCLA_16 (
  input  logic [15:0] A_in,
  input  logic [15:0] B_in,
  input  logic        C_in,
  output logic [15:0] S_out,
  output logic        C_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic        c4;
  logic        c8;
  logic        c12;

  assign g = A_in & B_in;
  assign p = A_in ^ B_in;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Group carries are fully expanded so no group waits on its neighbour.
  assign c4  = gg[0] | (gp[0] & C_in);
  assign c8  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & C_in);
  assign c12 = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
             | (gp[2] & gp[1] & gp[0] & C_in);
  assign C_out = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & C_in);

  always_comb begin
    logic [3:0] grp_cin;
    logic       carry;
    grp_cin = {c12, c8, c4, C_in};
    carry   = 1'b0;
    S_out   = '0;
    for (int k = 0; k < 4; k++) begin
      carry = grp_cin[k];
      for (int i = 0; i < 4; i++) begin
        S_out[4*k+i] = p[4*k+i] ^ carry;
        carry        = g[4*k+i] | (p[4*k+i] & carry);
      end
    end
  end

endmodule

// File: rtl/lcla_multiword_seq.sv
// Multi-word add/subtract sequencer: runs WORDS 16-bit slices through one
// shared LCLA_16, LSB slice first, carry registered between slices.
module lcla_multiword_seq
  import lcla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input logic                  CLK_in,
  input logic                  RSTn_in,
  lcla_multiword_seq_if.slave  bus
);

  localparam int IDX_W = clog2(WORDS);

  typedef logic [WORDS-1:0][SLICE_W-1:0] word_vec_t;

  logic [1:0]       state_q, state_d;
  word_vec_t        a_q, a_d;
  word_vec_t        b_q, b_d;
  word_vec_t        sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_c;
  logic               last_slice;

  assign last_slice = (idx_q == IDX_W'(WORDS - 1));

  LCLA_16 u_lcla (
    .A_in  (a_q[idx_q]),
    .B_in  (b_q[idx_q]),
    .C_in  (carry_q),
    .S_out (slice_s),
    .C_out (slice_c)
  );

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start_in) begin
          // Subtract is A + ~B + 1, so the mode is folded into B and the carry.
          a_d     = bus.A_in;
          b_d     = bus.Sub_in ? ~bus.B_in : bus.B_in;
          carry_d = bus.Sub_in ? 1'b1 : bus.C_in;
          sum_d   = '0;
          idx_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        sum_d[idx_q] = slice_s;
        carry_d      = slice_c;
        idx_d        = idx_q + 1'b1;
        if (last_slice) begin
          cout_d  = slice_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the operand and result words are plain flops, not RAM, so they are
  // reset along with the control state and every output is defined after reset.
  always_ff @(posedge CLK_in or negedge RSTn_in) begin
    if (!RSTn_in) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.Ready_out = (state_q == ST_IDLE);
  assign bus.Busy_out  = (state_q == ST_ADD);
  assign bus.Done_out  = (state_q == ST_DONE);
  assign bus.S_out     = sum_q;
  assign bus.C_out     = cout_q;

endmodule
